// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: steps a 3-input block under test through all eight
// input vectors, samples its output after a settle interval, builds the
// captured truth table and compares it against an expected pattern that was
// latched at START.
module truth_table_sequencer #(
   parameter int SETTLE = 4,   // cycles each vector is held before sampling (1..255)
   parameter int CW     = 8    // settle counter width; must hold SETTLE-1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic [7:0] EXP,
   input  logic       F,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       BUSY,
   output logic       DONE,
   output logic       PASS,
   output logic [7:0] TT,
   output logic [2:0] FAIL_IDX
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_CHECK  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam logic [CW-1:0] LP_CNT_LAST = CW'(SETTLE - 1);

   state_t        r_state;
   state_t        w_next;
   logic [2:0]    r_idx;
   logic [CW-1:0] r_cnt;
   logic [7:0]    r_exp;
   logic [7:0]    r_tt;
   logic          r_pass;
   logic [2:0]    r_fidx;
   logic [2:0]    r_abc;
   logic          r_busy;
   logic          r_done;

   // Lowest bit position where the captured and expected tables differ;
   // zero when they agree. Scanning downward leaves the lowest hit last.
   function automatic logic [2:0] first_mismatch(input logic [7:0] tt_v,
                                                 input logic [7:0] exp_v);
      logic [2:0] pos;
      pos = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (tt_v[i] != exp_v[i]) begin
            pos = 3'(i);
         end else begin
            pos = pos;
         end
      end
      return pos;
   endfunction

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic: settle for SETTLE cycles, sample once, repeat for all
   // eight vectors, then a single check cycle and a single done cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (START) begin
               w_next = ST_SETTLE;
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (r_cnt == LP_CNT_LAST) begin
               w_next = ST_SAMPLE;
            end else begin
               w_next = ST_SETTLE;
            end
         end
         ST_SAMPLE: begin
            if (r_idx == 3'd7) begin
               w_next = ST_CHECK;
            end else begin
               w_next = ST_SETTLE;
            end
         end
         ST_CHECK: w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Datapath: vector index, settle counter, stimulus, capture and result
   // registers. EXP is only latched on an accepted START so it may change
   // freely during a run.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_idx  <= 3'd0;
         r_cnt  <= '0;
         r_exp  <= 8'h00;
         r_tt   <= 8'h00;
         r_pass <= 1'b0;
         r_fidx <= 3'd0;
         r_abc  <= 3'd0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (START) begin
                  r_exp  <= EXP;
                  r_tt   <= 8'h00;
                  r_idx  <= 3'd0;
                  r_cnt  <= '0;
                  r_abc  <= 3'd0;
                  r_busy <= 1'b1;
               end
            end
            ST_SETTLE: begin
               r_cnt <= r_cnt + CW'(1);
            end
            ST_SAMPLE: begin
               r_tt[r_idx] <= F;
               // The final vector stays on A/B/C through the check cycle.
               if (r_idx != 3'd7) begin
                  r_idx <= r_idx + 3'd1;
                  r_abc <= r_idx + 3'd1;
                  r_cnt <= '0;
               end
            end
            ST_CHECK: begin
               r_pass <= (r_tt == r_exp);
               r_fidx <= first_mismatch(r_tt, r_exp);
               r_abc  <= 3'd0;
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
            ST_DONE: begin
               r_done <= 1'b0;
            end
            default: begin
               r_busy <= 1'b0;
            end
         endcase
      end
   end

   assign A        = r_abc[2];
   assign B        = r_abc[1];
   assign C        = r_abc[0];
   assign BUSY     = r_busy;
   assign DONE     = r_done;
   assign PASS     = r_pass;
   assign TT       = r_tt;
   assign FAIL_IDX = r_fidx;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: two instances (SETTLE=4 and SETTLE=1)
// share stimulus; the block under test is modelled as an 8-entry lookup
// table indexed by {A,B,C}.
module tb_truth_table_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       sel;
   logic [7:0] exp_in;
   logic [7:0] ftbl;

   logic       a0, b0, c0, busy0, done0, pass0, f0;
   logic [7:0] tt0;
   logic [2:0] fidx0;
   logic       a1, b1, c1, busy1, done1, pass1, f1;
   logic [7:0] tt1;
   logic [2:0] fidx1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign f0 = ftbl[{a0, b0, c0}];
   assign f1 = ftbl[{a1, b1, c1}];

   truth_table_sequencer #(.SETTLE(4), .CW(8)) u_dut0 (
      .CLK(clk), .RST(rst), .START(start & ~sel), .EXP(exp_in), .F(f0),
      .A(a0), .B(b0), .C(c0), .BUSY(busy0), .DONE(done0), .PASS(pass0),
      .TT(tt0), .FAIL_IDX(fidx0)
   );

   truth_table_sequencer #(.SETTLE(1), .CW(8)) u_dut1 (
      .CLK(clk), .RST(rst), .START(start & sel), .EXP(exp_in), .F(f1),
      .A(a1), .B(b1), .C(c1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
      .TT(tt1), .FAIL_IDX(fidx1)
   );

   // Outputs of whichever instance is currently selected.
   wire [2:0] m_abc  = sel ? {a1, b1, c1} : {a0, b0, c0};
   wire       m_busy = sel ? busy1 : busy0;
   wire       m_done = sel ? done1 : done0;
   wire       m_pass = sel ? pass1 : pass0;
   wire [7:0] m_tt   = sel ? tt1 : tt0;
   wire [2:0] m_fidx = sel ? fidx1 : fidx0;

   typedef struct {
      logic [7:0] ft;
      logic [7:0] ex;
      logic       pass;
      logic [2:0] fidx;
   } vec_t;

   vec_t vecs[3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: the first index whose expected bit differs, 0 if none.
   function automatic logic [2:0] ref_fidx(input logic [7:0] t, input logic [7:0] e);
      for (int i = 0; i < 8; i++) begin
         if (t[i] != e[i]) return 3'(i);
      end
      return 3'd0;
   endfunction

   // One full run: START pulse, per-cycle check of stimulus/BUSY/DONE,
   // results checked in the DONE cycle. Optional mid-run EXP change and
   // START pokes while busy and in DONE.
   task automatic run_check(input int s, input logic [7:0] ft, input logic [7:0] ex,
                            input logic mid_change, input logic poke, input string name);
      int total;
      int period;
      logic [2:0] want_abc;
      logic [7:0] ex_used;
      ex_used = ex;
      period  = s + 1;
      total   = 8 * period + 2;
      ftbl    = ft;
      @(posedge clk); #1;
      exp_in = ex;
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (mid_change) exp_in = 8'h00;
      for (int k = 1; k <= total; k++) begin
         @(negedge clk);
         if (k <= 8 * period + 1) begin
            want_abc = ((k - 1) / period > 7) ? 3'd7 : 3'((k - 1) / period);
         end else begin
            want_abc = 3'd0;
         end
         chk({name, "_abc"}, 32'(m_abc), 32'(want_abc));
         chk({name, "_busy"}, 32'(m_busy), 32'(k < total));
         chk({name, "_done"}, 32'(m_done), 32'(k == total));
         if (k == total) begin
            chk({name, "_tt"}, 32'(m_tt), 32'(ft));
            chk({name, "_pass"}, 32'(m_pass), 32'(ft == ex_used));
            chk({name, "_fidx"}, 32'(m_fidx), 32'(ref_fidx(ft, ex_used)));
         end
         if (poke) begin
            if (k == 10 || k == total) start = 1'b1;
            else start = 1'b0;
         end
      end
      if (poke) begin
         @(posedge clk); #1;
         start = 1'b0;
         @(negedge clk);
         chk({name, "_no_restart"}, 32'(m_busy), 32'd0);
      end
   endtask

   initial begin
      logic [7:0] rf;
      logic [7:0] re;
      rst = 1'b1; start = 1'b0; sel = 1'b0; exp_in = 8'h00; ftbl = 8'hEA;
      vecs[0] = '{ft: 8'hEA, ex: 8'hEA, pass: 1'b1, fidx: 3'd0};
      vecs[1] = '{ft: 8'hEA, ex: 8'hEE, pass: 1'b0, fidx: 3'd2};
      vecs[2] = '{ft: 8'hEA, ex: 8'h6A, pass: 1'b0, fidx: 3'd7};

      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         sel = d[0];
         #1;
         chk("rst_abc", 32'(m_abc), 32'd0);
         chk("rst_busy", 32'(m_busy), 32'd0);
         chk("rst_done", 32'(m_done), 32'd0);
         chk("rst_pass", 32'(m_pass), 32'd0);
         chk("rst_tt", 32'(m_tt), 32'd0);
         chk("rst_fidx", 32'(m_fidx), 32'd0);
      end
      sel = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      // Table-driven directed runs with the (A&B)|C block.
      for (int v = 0; v < 3; v++) begin
         run_check(4, vecs[v].ft, vecs[v].ex, 1'b0, 1'b0, "vec");
         chk("vec_pass_tbl", 32'(pass0), 32'(vecs[v].pass));
         chk("vec_fidx_tbl", 32'(fidx0), 32'(vecs[v].fidx));
      end

      // Latched EXP and START pokes while busy / in DONE.
      run_check(4, 8'hEA, 8'hEA, 1'b1, 1'b1, "latch");

      // Reset while vector 3 is being driven.
      ftbl = 8'hEA;
      @(posedge clk); #1;
      exp_in = 8'hEA; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         if (k == 16) chk("abort_idx3", 32'(m_abc), 32'd3);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_abc", 32'(m_abc), 32'd0);
      chk("abort_busy", 32'(m_busy), 32'd0);
      chk("abort_tt", 32'(m_tt), 32'd0);
      chk("abort_pass", 32'(m_pass), 32'd0);
      chk("abort_done", 32'(m_done), 32'd0);
      run_check(4, 8'hEA, 8'hEA, 1'b0, 1'b0, "post_abort");

      // SETTLE=1 instance.
      sel = 1'b1;
      run_check(1, 8'hFF, 8'hFF, 1'b0, 1'b0, "s1_ones");
      run_check(1, 8'h00, 8'hFF, 1'b0, 1'b0, "s1_zeros");
      sel = 1'b0;

      // START held high: back-to-back runs.
      ftbl = 8'hEA;
      @(posedge clk); #1;
      exp_in = 8'hEA; start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         chk("b2b_done", 32'(done0), 32'(k == 42 || k == 85));
         if (k >= 42) begin
            chk("b2b_pass", 32'(pass0), 32'd1);
            chk("b2b_fidx", 32'(fidx0), 32'd0);
         end
         if (k == 42 || k == 43) chk("b2b_tt_hold", 32'(tt0), 32'hEA);
         if (k == 44) chk("b2b_tt_clear", 32'(tt0), 32'd0);
      end
      start = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

      // Randomized block functions and expected tables.
      for (int r = 0; r < 16; r++) begin
         rf = 8'($urandom);
         re = ($urandom_range(0, 3) == 0) ? rf : 8'($urandom);
         sel = ($urandom_range(0, 1) == 1);
         run_check(sel ? 1 : 4, rf, re, 1'b0, 1'b0, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
